// File: rtl/dense_engine_if.sv
// -----------------------------------------------------------------------------
// dense_engine_if
// Stream handshake bundle for dense_engine.
//   in_valid / in_ready    : input beat handshake (producer -> engine)
//   in_data / in_weight    : TAPS packed signed values, tap 0 in the LSBs
//   out_valid / out_ready  : result handshake (engine -> consumer)
//   out_data               : signed neuron result
// Modports: master = producer/consumer side, slave = engine side.
// -----------------------------------------------------------------------------
interface dense_engine_if #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 9
);
    logic                     in_valid;
    logic                     in_ready;
    logic [TAPS*DATA_W-1:0]   in_data;
    logic [TAPS*DATA_W-1:0]   in_weight;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_weight, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_weight, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dense_engine.sv
// -----------------------------------------------------------------------------
// dense_engine
// One fully-connected neuron: accumulates TAPS signed products per accepted
// beat over num_chunks beats, then outputs sat((acc >>> FRAC_BITS) + bias),
// optionally passed through ReLU.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   start      : begin a neuron (sampled only in IDLE)
//   num_chunks : beats per neuron (0 treated as 1), sampled at start
//   last_valid : live taps in the final beat (0 or >TAPS treated as TAPS)
//   bias       : signed bias, sampled at start
//   relu_en    : ReLU enable, sampled at start
//   bus        : input beat / result handshakes (slave modport)
//   busy       : high whenever the engine is not IDLE
// -----------------------------------------------------------------------------
module dense_engine #(
    parameter int DATA_W    = 16,
    parameter int TAPS      = 9,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 48,
    localparam int LV_W     = $clog2(TAPS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [15:0]              num_chunks,
    input  logic [LV_W-1:0]          last_valid,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     relu_en,
    dense_engine_if.slave            bus,
    output logic                     busy
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(TAPS) + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    // Output limits expressed at the width of the result adder.
    localparam logic signed [ACC_W:0] R_MAX =
        {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] R_MIN =
        {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic [15:0]              chunk_cnt_q;
    logic [15:0]              last_chunk_q;   // index of the final beat
    logic [LV_W-1:0]          lv_q;           // already normalised to 1..TAPS
    logic signed [DATA_W-1:0] bias_q;
    logic                     relu_q;

    logic                     xfer;
    logic                     is_last;
    logic signed [SUM_W-1:0]  beat_sum;
    logic signed [ACC_W:0]    acc_sum;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  acc_shift;
    logic signed [ACC_W:0]    r_wide;
    logic signed [DATA_W-1:0] r_sat;
    logic signed [DATA_W-1:0] r_final;

    assign xfer    = bus.in_valid && bus.in_ready;
    assign is_last = (chunk_cnt_q == last_chunk_q);

    // Full-precision dot product of one beat; taps past last_valid in the
    // final beat are dropped so their (garbage) operands never matter.
    always_comb begin
        logic signed [DATA_W-1:0] d;
        logic signed [DATA_W-1:0] w;
        logic signed [PROD_W-1:0] prod;
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        beat_sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            d    = bus.in_data[i*DATA_W +: DATA_W];
            w    = bus.in_weight[i*DATA_W +: DATA_W];
            prod = d * w;
            if (!(is_last && i >= int'(lv_q)))
                beat_sum = beat_sum + SUM_W'(prod);
        end
    end

    // One extra bit catches overflow; clamp instead of wrapping.
    always_comb begin
        acc_sum  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(beat_sum);
        acc_next = acc_sum[ACC_W-1:0];
        if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
            acc_next = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end

    // Result: arithmetic shift (floor), add bias, saturate, optional ReLU.
    always_comb begin
        acc_shift = acc_q >>> FRAC_BITS;
        r_wide    = (ACC_W+1)'(acc_shift) + (ACC_W+1)'(bias_q);
        if (r_wide > R_MAX)
            r_sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (r_wide < R_MIN)
            r_sat = {1'b1, {(DATA_W-1){1'b0}}};
        else
            r_sat = r_wide[DATA_W-1:0];
        r_final = (relu_q && r_sat[DATA_W-1]) ? '0 : r_sat;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)              state_d = ACCUM;
            ACCUM:   if (xfer && is_last)    state_d = OUTPUT;
            OUTPUT:  if (bus.out_ready)      state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q        <= '0;
            chunk_cnt_q  <= '0;
            last_chunk_q <= '0;
            lv_q         <= '0;
            bias_q       <= '0;
            relu_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    acc_q        <= '0;
                    chunk_cnt_q  <= '0;
                    last_chunk_q <= (num_chunks == 16'd0) ? 16'd0 : num_chunks - 16'd1;
                    lv_q         <= (last_valid == '0 || int'(last_valid) > TAPS)
                                    ? LV_W'(TAPS) : last_valid;
                    bias_q       <= bias;
                    relu_q       <= relu_en;
                end
                ACCUM: if (xfer) begin
                    acc_q       <= acc_next;
                    chunk_cnt_q <= chunk_cnt_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from state so reset clears them immediately.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == OUTPUT);
    assign bus.out_data  = (state_q == OUTPUT) ? r_final : '0;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dense_engine.sv
// -----------------------------------------------------------------------------
// tb_dense_engine
// Directed, table-driven bench for dense_engine (DATA_W=16, TAPS=9,
// FRAC_BITS=8) plus hand-written stall, backpressure and reset sequences.
// -----------------------------------------------------------------------------
module tb_dense_engine;

    localparam int DATA_W    = 16;
    localparam int TAPS      = 9;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 48;
    localparam int LV_W      = $clog2(TAPS + 1);

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     start = 1'b0;
    logic [15:0]              num_chunks = '0;
    logic [LV_W-1:0]          last_valid = '0;
    logic signed [DATA_W-1:0] bias = '0;
    logic                     relu_en = 1'b0;
    logic                     busy;

    dense_engine_if #(.DATA_W(DATA_W), .TAPS(TAPS)) bus();

    dense_engine #(
        .DATA_W(DATA_W), .TAPS(TAPS), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks),
        .last_valid(last_valid), .bias(bias), .relu_en(relu_en),
        .bus(bus), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string name;
        int    nc;       // num_chunks as driven
        int    lv;       // last_valid as driven
        int    b;        // bias
        bit    relu;
        int    dv;       // data value on every live tap
        int    wv;       // weight value on every live tap
        bit    garbage;  // put junk on masked taps of the final beat
        int    exp;      // hand-computed out_data
    } vec_t;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        tick();
    endtask

    task automatic drive_beat(input int dv, input int wv, input bit last,
                              input int lv_eff, input bit garbage);
        logic signed [DATA_W-1:0] d;
        logic signed [DATA_W-1:0] w;
        for (int i = 0; i < TAPS; i++) begin
            if (last && garbage && i >= lv_eff) begin
                d = 16'(1000 + 37 * i);
                w = 16'(-3000 - i);
            end else begin
                d = 16'(dv);
                w = 16'(wv);
            end
            bus.in_data[i*DATA_W +: DATA_W]   = d;
            bus.in_weight[i*DATA_W +: DATA_W] = w;
        end
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!bus.out_valid) begin
            check({name, " timeout"}, bus.out_valid, 1);
            hard_reset();
        end
    endtask

    task automatic pulse_start(input int nc, input int lv, input int b,
                               input bit relu);
        num_chunks = 16'(nc);
        last_valid = LV_W'(lv);
        bias       = 16'(b);
        relu_en    = relu;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int nc_eff;
        int lv_eff;
        nc_eff = (v.nc == 0) ? 1 : v.nc;
        lv_eff = (v.lv == 0 || v.lv > TAPS) ? TAPS : v.lv;
        pulse_start(v.nc, v.lv, v.b, v.relu);
        check({v.name, " busy"}, busy, 1);
        check({v.name, " out_data idle"}, bus.out_data, 0);
        bus.in_valid = 1'b1;
        for (int beat = 0; beat < nc_eff; beat++) begin
            drive_beat(v.dv, v.wv, beat == nc_eff - 1, lv_eff, v.garbage);
            tick();
        end
        bus.in_valid = 1'b0;
        check({v.name, " latency"}, bus.out_valid, 1);
        wait_out(v.name);
        check({v.name, " out_data"}, bus.out_data, v.exp);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({v.name, " done"}, bus.out_valid, 0);
    endtask

    vec_t vecs[10];
    int   beats;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        bus.in_weight = '0;

        vecs[0] = '{"single",      1, 9,    0, 0,    256,   256, 0,   2304};
        vecs[1] = '{"mask3",       1, 3,    0, 0,    256,   256, 1,    768};
        vecs[2] = '{"mask3_bias",  1, 3, -256, 0,    256,   256, 1,    512};
        vecs[3] = '{"sat_pos",     4, 9,    0, 0,  32767, 32767, 0,  32767};
        vecs[4] = '{"sat_neg",     4, 9,    0, 0, -32768, 32767, 0, -32768};
        vecs[5] = '{"sat_relu",    4, 9,    0, 1, -32768, 32767, 0,      0};
        vecs[6] = '{"nc0_lv0",     0, 0,    0, 0,    256,   256, 0,   2304};
        vecs[7] = '{"floor",       1, 1,    0, 0,     -1,     1, 1,     -1};
        vecs[8] = '{"lv_over",     1, 12,   0, 0,    256,   256, 0,   2304};
        vecs[9] = '{"two_chunk",   2, 5,  100, 0,    256,  -512, 1,  -7068};

        // Reset state, checked while rst is still asserted.
        #12;
        check("reset in_ready",  bus.in_ready,  0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_data",  bus.out_data,  0);
        check("reset busy",      busy,          0);
        #10;
        rst = 1'b1;
        tick();

        // Idle ignores in_valid.
        bus.in_valid = 1'b1;
        tick();
        check("idle in_ready", bus.in_ready, 0);
        check("idle busy",     busy,         0);
        bus.in_valid = 1'b0;

        for (int k = 0; k < 10; k++) run_vec(vecs[k]);

        // Multi-chunk with in_valid toggling every cycle.
        pulse_start(3, 9, 0, 0);
        drive_beat(256, 256, 0, TAPS, 0);
        beats = 0;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = (c % 2 == 0);
            if (bus.in_valid && bus.in_ready) beats++;
            tick();
            if (c == 4) check("stall latency", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        check("stall beats",    beats,         3);
        check("stall in_ready", bus.in_ready,  0);
        wait_out("stall");
        check("stall out_data", bus.out_data,  6912);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Backpressure: result held, start ignored, also on the handshake.
        pulse_start(1, 9, 0, 0);
        drive_beat(256, 256, 1, TAPS, 0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out("bp");
        for (int c = 0; c < 5; c++) begin
            start = 1'b1;
            check("bp out_data", bus.out_data, 2304);
            check("bp busy",     busy,         1);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        start         = 1'b0;
        bus.out_ready = 1'b0;
        check("bp release valid", bus.out_valid, 0);
        check("bp release busy",  busy,          0);
        tick();
        check("bp start ignored", busy, 0);

        // Reset mid-ACCUM after one of three beats.
        pulse_start(3, 9, 0, 0);
        drive_beat(32767, 32767, 0, TAPS, 0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("abort in_ready",  bus.in_ready,  0);
        check("abort out_valid", bus.out_valid, 0);
        check("abort out_data",  bus.out_data,  0);
        check("abort busy",      busy,          0);
        #1;
        rst = 1'b1;
        tick();
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
